// File: rtl/parallel_transmitter_pkg.sv
// rtl/parallel_transmitter_pkg.sv - shared types and constants for the parallel link transmitter
package parallel_transmitter_pkg;

  localparam int LINK_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETUP   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } tx_state_e;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parallel_transmitter_fifo.sv
// rtl/parallel_transmitter_fifo.sv - synchronous FIFO with registered read data
module parallel_transmitter_fifo
  import parallel_transmitter_pkg::*;
#(
  parameter int W     = LINK_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic         clk_rx,
  input  logic         rst_rx,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2_min1(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_acc;
  logic          rd_acc;

  // A write at full is dropped even if a read frees a slot in the same cycle.
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk_rx) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/parallel_transmitter_sync.sv
// rtl/parallel_transmitter_sync.sv - two-flop synchroniser for the far-end ready
module parallel_transmitter_sync (
  input  logic clk_rx,
  input  logic rst_rx,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) sync_ff <= 2'b00;
    else        sync_ff <= {sync_ff[0], async_in};
  end

  assign sync_out = sync_ff[1];

endmodule

// File: rtl/parallel_transmitter.sv
// rtl/parallel_transmitter.sv - FIFO-fed transmit side of the 4-phase valid/ready parallel link
module parallel_transmitter
  import parallel_transmitter_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                   clk_rx,
  input  logic                   rst_rx,
  input  logic [LINK_DATA_W-1:0] data_in,
  input  logic                   wr_en,
  output logic                   fifo_full,
  output logic                   tx_busy,
  output logic [LINK_DATA_W-1:0] parallel_data_out,
  output logic                   parallel_valid_out,
  input  logic                   parallel_ready_in,
  output logic                   timeout_err,
  input  logic                   clr_err,
  output logic [CNT_W-1:0]       word_count
);

  localparam int SETUP_W = clog2_min1(SETUP_CYCLES);
  localparam int TMO_W   = clog2_min1(TIMEOUT_CYCLES);
  localparam bit TMO_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  tx_state_e              state;
  tx_state_e              state_nxt;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [LINK_DATA_W-1:0] fifo_rd_data;
  logic                   ready_sync;
  logic [SETUP_W-1:0]     setup_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   tmo_abort;
  logic                   load_word;
  logic                   set_valid;
  logic                   clr_valid;
  logic                   tmo_hit;
  logic                   count_inc;

  parallel_transmitter_fifo #(
    .W     (LINK_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_rx  (clk_rx),
    .rst_rx  (rst_rx),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  parallel_transmitter_sync u_ready_sync (
    .clk_rx   (clk_rx),
    .rst_rx   (rst_rx),
    .async_in (parallel_ready_in),
    .sync_out (ready_sync)
  );

  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = LOAD;
      LOAD:    state_nxt = SETUP;
      SETUP:   if (setup_cnt == SETUP_LAST) state_nxt = WAIT_HI;
      WAIT_HI: if (ready_sync || tmo_hit) state_nxt = WAIT_LO;
      WAIT_LO: if (!ready_sync || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A timeout only fires while the awaited ready level is still missing.
  always_comb begin
    fifo_rd_en = (state == IDLE) && !fifo_empty;
    load_word  = (state == LOAD);
    set_valid  = (state == SETUP) && (setup_cnt == SETUP_LAST);
    tmo_hit    = TMO_EN && (tmo_cnt == TMO_LAST) &&
                 (((state == WAIT_HI) && !ready_sync) || ((state == WAIT_LO) && ready_sync));
    clr_valid  = (state == WAIT_HI) && (ready_sync || tmo_hit);
    count_inc  = (state == WAIT_LO) && !ready_sync && !tmo_abort;
  end

  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      parallel_data_out  <= '0;
      parallel_valid_out <= 1'b0;
      setup_cnt          <= '0;
      tmo_cnt            <= '0;
      tmo_abort          <= 1'b0;
      timeout_err        <= 1'b0;
      word_count         <= '0;
    end else begin
      if (load_word) begin
        parallel_data_out <= fifo_rd_data;
        setup_cnt         <= '0;
        tmo_abort         <= 1'b0;
      end else if (state == SETUP) begin
        setup_cnt <= setup_cnt + SETUP_W'(1);
      end

      if (set_valid)      parallel_valid_out <= 1'b1;
      else if (clr_valid) parallel_valid_out <= 1'b0;

      // Restart the phase timer on every state change so each wait phase gets a full budget.
      if (state_nxt != state) tmo_cnt <= '0;
      else if ((state == WAIT_HI) || (state == WAIT_LO)) tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (tmo_hit && (state == WAIT_HI)) tmo_abort <= 1'b1;

      if (tmo_hit)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      if (count_inc) word_count <= word_count + CNT_W'(1);
    end
  end

  assign tx_busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_parallel_transmitter.sv
// tb/tb_parallel_transmitter.sv - directed and table-driven bench for parallel_transmitter
module tb_parallel_transmitter;

  logic        clk_rx;
  logic        rst_rx;
  logic [15:0] data_in;
  logic        wr_en;
  logic        fifo_full;
  logic        tx_busy;
  logic [15:0] parallel_data_out;
  logic        parallel_valid_out;
  logic        parallel_ready_in;
  logic        timeout_err;
  logic        clr_err;
  logic [3:0]  word_count;

  parallel_transmitter #(
    .SETUP_CYCLES   (2),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_rx             (clk_rx),
    .rst_rx             (rst_rx),
    .data_in            (data_in),
    .wr_en              (wr_en),
    .fifo_full          (fifo_full),
    .tx_busy            (tx_busy),
    .parallel_data_out  (parallel_data_out),
    .parallel_valid_out (parallel_valid_out),
    .parallel_ready_in  (parallel_ready_in),
    .timeout_err        (timeout_err),
    .clr_err            (clr_err),
    .word_count         (word_count)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  exp_count;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          stab_err = 0;
  int          rerise_err = 0;
  bit          never_ready = 0;
  logic [15:0] rx_q[$];
  logic [15:0] exp_q[$];
  vec_t        vecs[16];

  initial begin
    clk_rx = 0;
    forever #5 clk_rx = ~clk_rx;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rx_pop();
    if (rx_q.size() == 0) return 16'hxxxx;
    return rx_q.pop_front();
  endfunction

  // Far-end receiver: raise ready after 3 cycles of valid, drop it 2 cycles after valid falls.
  initial begin
    int hi;
    int lo;
    hi = 0;
    lo = 0;
    parallel_ready_in = 0;
    forever begin
      @(negedge clk_rx);
      if (rst_rx || never_ready) begin
        parallel_ready_in = 0;
        hi = 0;
        lo = 0;
      end else if (!parallel_ready_in) begin
        if (parallel_valid_out) begin
          hi++;
          if (hi == 3) begin parallel_ready_in = 1; hi = 0; end
        end else hi = 0;
      end else if (!parallel_valid_out) begin
        lo++;
        if (lo == 2) begin parallel_ready_in = 0; lo = 0; end
      end
    end
  end

  // Link monitor: capture words on valid rise, flag data changes mid-handshake.
  initial begin
    bit          prev_valid;
    bit          in_hs;
    logic [15:0] hs_data;
    prev_valid = 0;
    in_hs = 0;
    hs_data = 0;
    forever begin
      @(negedge clk_rx);
      if (rst_rx) begin
        prev_valid = 0;
        in_hs = 0;
      end else begin
        if (parallel_valid_out && !prev_valid) begin
          rx_q.push_back(parallel_data_out);
          hs_data = parallel_data_out;
          in_hs = 1;
          if (parallel_ready_in) rerise_err++;
        end else if (in_hs && (parallel_valid_out || parallel_ready_in) &&
                     parallel_data_out !== hs_data) begin
          stab_err++;
        end
        if (!parallel_valid_out && !parallel_ready_in) in_hs = 0;
        prev_valid = parallel_valid_out;
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    data_in = w;
    wr_en = 1;
    @(posedge clk_rx);
    #1;
    wr_en = 0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((tx_busy || parallel_valid_out || parallel_ready_in) && k < 3000) begin
      @(posedge clk_rx);
      #1;
      k++;
    end
    if (k >= 3000) check({name, "_idle_timeout"}, 1, 0);
  endtask

  initial begin
    int first_k;
    int hi_cnt;
    int sent;
    int budget;

    vecs[0]  = '{16'h0000, 4'd2};  vecs[1]  = '{16'hFFFF, 4'd3};
    vecs[2]  = '{16'h5A5A, 4'd4};  vecs[3]  = '{16'hA5A5, 4'd5};
    vecs[4]  = '{16'h0001, 4'd6};  vecs[5]  = '{16'h8000, 4'd7};
    vecs[6]  = '{16'h1234, 4'd8};  vecs[7]  = '{16'hFEDC, 4'd9};
    vecs[8]  = '{16'h00FF, 4'd10}; vecs[9]  = '{16'hFF00, 4'd11};
    vecs[10] = '{16'h0F0F, 4'd12}; vecs[11] = '{16'hF0F0, 4'd13};
    vecs[12] = '{16'h3C3C, 4'd14}; vecs[13] = '{16'hC3C3, 4'd15};
    vecs[14] = '{16'h7FFF, 4'd0};  vecs[15] = '{16'hDEAD, 4'd1};

    rst_rx = 1;
    data_in = 0;
    wr_en = 0;
    clr_err = 0;
    repeat (3) @(posedge clk_rx);
    #1;
    check("rst_valid", parallel_valid_out, 0);
    check("rst_data", parallel_data_out, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_word_count", word_count, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    @(negedge clk_rx);
    #1 rst_rx = 0;
    @(posedge clk_rx);
    #1;

    // Single word: data on link at edge 2, valid at edge 2+SETUP_CYCLES.
    data_in = 16'hA5C3;
    wr_en = 1;
    @(posedge clk_rx);
    #1;
    wr_en = 0;
    first_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_rx);
      #1;
      if (k == 1) check("t1_data_edge1", parallel_data_out, 16'h0000);
      if (k == 2) check("t1_data_edge2", parallel_data_out, 16'hA5C3);
      if (parallel_valid_out && first_k < 0) first_k = k;
    end
    check("t1_valid_edge", first_k, 4);
    wait_idle("t1");
    check("t1_word_count", word_count, 1);
    check("t1_rx_word", rx_pop(), 16'hA5C3);

    // Table: one word per entry; word_count (4 bits) wraps through 15 -> 0 -> 1.
    for (int i = 0; i < 16; i++) begin
      send_word(vecs[i].data);
      wait_idle("tbl");
      check($sformatf("tbl%0d_count", i), word_count, vecs[i].exp_count);
      check($sformatf("tbl%0d_rx", i), rx_pop(), vecs[i].data);
    end

    // Burst of 20 with a silent far end: w0 times out, only w0..w4 fit in the FIFO.
    never_ready = 1;
    hi_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (k < 20) begin
        data_in = 16'h1000 + 16'(k);
        wr_en = 1;
      end else wr_en = 0;
      @(posedge clk_rx);
      #1;
      if (parallel_valid_out) hi_cnt++;
      if (k == 4) check("burst_full", fifo_full, 1);
      if (k == 19) check("burst_valid_before_tmo", parallel_valid_out, 1);
      if (k == 20) begin
        check("burst_valid_after_tmo", parallel_valid_out, 0);
        check("burst_timeout_err", timeout_err, 1);
      end
      if (k == 22) never_ready = 0;
    end
    check("burst_valid_high_cycles", hi_cnt, 16);
    wait_idle("burst");
    check("burst_word_count", word_count, 5);
    check("burst_rx_size", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("burst_rx%0d", i), rx_pop(), 16'h1000 + 16'(i));

    // clr_err coinciding with a fresh timeout leaves the flag set.
    clr_err = 1;
    @(posedge clk_rx);
    #1;
    clr_err = 0;
    check("clr_err_clears", timeout_err, 0);
    never_ready = 1;
    send_word(16'hBEEF);
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) clr_err = 1;
      @(posedge clk_rx);
      #1;
      if (k == 19) check("clr_pre_tmo_err", timeout_err, 0);
    end
    check("clr_set_wins", timeout_err, 1);
    check("clr_valid_dropped", parallel_valid_out, 0);
    clr_err = 0;
    @(posedge clk_rx);
    #1;
    check("clr_err_sticky", timeout_err, 1);
    wait_idle("clr");
    never_ready = 0;
    check("clr_word_count", word_count, 5);
    check("clr_rx_word", rx_pop(), 16'hBEEF);
    clr_err = 1;
    @(posedge clk_rx);
    #1;
    clr_err = 0;
    check("clr_err_cleared", timeout_err, 0);

    // Reset in WAIT_HI with a second word queued.
    never_ready = 1;
    data_in = 16'h7777;
    wr_en = 1;
    @(posedge clk_rx);
    #1;
    data_in = 16'h8888;
    @(posedge clk_rx);
    #1;
    wr_en = 0;
    budget = 0;
    while (!parallel_valid_out && budget < 20) begin
      @(posedge clk_rx);
      #1;
      budget++;
    end
    check("rst_mid_reached_wait_hi", parallel_valid_out, 1);
    @(posedge clk_rx);
    #1;
    rst_rx = 1;
    #1;
    check("rst_mid_valid", parallel_valid_out, 0);
    check("rst_mid_data", parallel_data_out, 0);
    check("rst_mid_count", word_count, 0);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_full", fifo_full, 0);
    @(negedge clk_rx);
    #1;
    rst_rx = 0;
    never_ready = 0;
    rx_q.delete();
    @(posedge clk_rx);
    #1;

    // 100 random words streamed with flow control.
    sent = 0;
    budget = 0;
    while (sent < 100 && budget < 5000) begin
      if (!fifo_full) begin
        data_in = 16'($urandom);
        wr_en = 1;
        exp_q.push_back(data_in);
        sent++;
      end else wr_en = 0;
      @(posedge clk_rx);
      #1;
      budget++;
    end
    wr_en = 0;
    if (budget >= 5000) check("rand_send_timeout", 1, 0);
    wait_idle("rand");
    check("rand_rx_size", rx_q.size(), 100);
    check("rand_word_count", word_count, 4);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++)
      check($sformatf("rand_rx%0d", i), rx_pop(), exp_q.pop_front());

    check("link_data_stable", stab_err, 0);
    check("valid_rerise_with_ready", rerise_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
